// File: rtl/machine_timer_irq_src.sv
// -----------------------------------------------------------------------------
// machine_timer_irq_src
//
// RISC-V style machine timer (mtime / mtimecmp) that produces the
// timer_timeout level consumed by the core controller's interrupt path.
// A prescaled 64-bit free-running counter is compared against a 64-bit
// compare value; the rising edge of the compare condition sets a sticky
// PENDING flag and, in periodic mode, advances mtimecmp by PERIOD.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   bus_req_i       register access request (accepted when no ack pending)
//   bus_we_i        1 = write, 0 = read
//   bus_addr_i      block-local byte offset (word aligned)
//   bus_wdata_i     write data
//   bus_ack_o       one-cycle completion, one cycle after acceptance
//   bus_rdata_o     registered read data, nonzero only with bus_ack_o
//   count_en_i      global count enable from the controller
//   timer_timeout   registered interrupt level to the controller
//   cmp_hit_o       one-cycle pulse on each compare rising edge
//
// Register map
//   0x00 MTIME_LO     0x04 MTIME_HI (returns shadow captured by LO read)
//   0x08 MTIMECMP_LO  0x0C MTIMECMP_HI
//   0x10 CTRL  bit0 EN, bit1 PERIODIC
//   0x14 PRESCALE (low PRESCALE_W bits)
//   0x18 PERIOD
//   0x1C STATUS bit0 PENDING, write-1-to-clear
//   other offsets read 0, writes ignored, still acked
// -----------------------------------------------------------------------------
module machine_timer_irq_src #(
    parameter int PRESCALE_W = 16,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_req_i,
    input  logic              bus_we_i,
    input  logic [ADDR_W-1:0] bus_addr_i,
    input  logic [31:0]       bus_wdata_i,
    output logic              bus_ack_o,
    output logic [31:0]       bus_rdata_o,
    input  logic              count_en_i,
    output logic              timer_timeout,
    output logic              cmp_hit_o
);

    localparam logic [ADDR_W-1:0] A_MTIME_LO = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_MTIME_HI = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_CMP_LO   = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_CMP_HI   = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] A_PRESCALE = ADDR_W'(32'h14);
    localparam logic [ADDR_W-1:0] A_PERIOD   = ADDR_W'(32'h18);
    localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(32'h1C);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [63:0]           mtime_q,     mtime_d;
    logic [63:0]           mtimecmp_q,  mtimecmp_d;
    logic                  en_q,        en_d;
    logic                  periodic_q,  periodic_d;
    logic [PRESCALE_W-1:0] prescale_q,  prescale_d;
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [31:0]           period_q,    period_d;
    logic                  pending_q,   pending_d;
    logic                  hit_q,       hit_d;
    logic                  timeout_q,   timeout_d;
    logic [31:0]           shadow_q,    shadow_d;
    logic                  ack_q,       ack_d;
    logic [31:0]           rdata_q,     rdata_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic accept;
    logic wr_en;
    logic rd_en;
    logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;
    logic wr_ctrl, wr_prescale, wr_period, wr_status;
    logic [31:0] rd_mux;

    // An ack cycle blocks acceptance, so a held request costs 2 cycles/access.
    assign accept = bus_req_i && !ack_q;
    assign wr_en  = accept && bus_we_i;
    assign rd_en  = accept && !bus_we_i;

    assign wr_mtime_lo = wr_en && (bus_addr_i == A_MTIME_LO);
    assign wr_mtime_hi = wr_en && (bus_addr_i == A_MTIME_HI);
    assign wr_cmp_lo   = wr_en && (bus_addr_i == A_CMP_LO);
    assign wr_cmp_hi   = wr_en && (bus_addr_i == A_CMP_HI);
    assign wr_ctrl     = wr_en && (bus_addr_i == A_CTRL);
    assign wr_prescale = wr_en && (bus_addr_i == A_PRESCALE);
    assign wr_period   = wr_en && (bus_addr_i == A_PERIOD);
    assign wr_status   = wr_en && (bus_addr_i == A_STATUS);

    always_comb begin
        rd_mux = '0;
        case (bus_addr_i)
            A_MTIME_LO: rd_mux = mtime_q[31:0];
            A_MTIME_HI: rd_mux = shadow_q;
            A_CMP_LO:   rd_mux = mtimecmp_q[31:0];
            A_CMP_HI:   rd_mux = mtimecmp_q[63:32];
            A_CTRL:     rd_mux = {30'd0, periodic_q, en_q};
            A_PRESCALE: rd_mux = 32'(prescale_q);
            A_PERIOD:   rd_mux = period_q;
            A_STATUS:   rd_mux = {31'd0, pending_q};
            default:    rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Time base and compare
    // ------------------------------------------------------------------
    logic tick;
    logic hit;
    logic hit_rise;

    assign tick     = en_q && count_en_i && (presc_cnt_q == prescale_q);
    assign hit      = en_q && (mtime_q >= mtimecmp_q);
    assign hit_rise = hit && !hit_q;

    always_comb begin
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        en_d        = en_q;
        periodic_d  = periodic_q;
        prescale_d  = prescale_q;
        presc_cnt_d = presc_cnt_q;
        period_d    = period_q;
        pending_d   = pending_q;
        shadow_d    = shadow_q;
        hit_d       = hit;
        ack_d       = accept;
        rdata_d     = rd_en ? rd_mux : 32'd0;

        // Prescaler: a PRESCALE write restarts the divide phase.
        if (wr_prescale) begin
            presc_cnt_d = '0;
        end else if (tick) begin
            presc_cnt_d = '0;
        end else if (en_q && count_en_i) begin
            presc_cnt_d = presc_cnt_q + PRESCALE_W'(1);
        end

        // mtime: software writes beat the tick; only the addressed half moves.
        if (wr_mtime_lo) begin
            mtime_d = {mtime_q[63:32], bus_wdata_i};
        end else if (wr_mtime_hi) begin
            mtime_d = {bus_wdata_i, mtime_q[31:0]};
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        // mtimecmp: software writes beat the periodic reload. PERIOD=0 adds
        // nothing, which degenerates naturally to one-shot behaviour.
        if (wr_cmp_lo) begin
            mtimecmp_d = {mtimecmp_q[63:32], bus_wdata_i};
        end else if (wr_cmp_hi) begin
            mtimecmp_d = {bus_wdata_i, mtimecmp_q[31:0]};
        end else if (hit_rise && periodic_q) begin
            mtimecmp_d = mtimecmp_q + {32'd0, period_q};
        end

        if (wr_ctrl) begin
            en_d       = bus_wdata_i[0];
            periodic_d = bus_wdata_i[1];
        end
        if (wr_prescale) begin
            prescale_d = bus_wdata_i[PRESCALE_W-1:0];
        end
        if (wr_period) begin
            period_d = bus_wdata_i;
        end

        // A fresh compare edge outranks a simultaneous W1C.
        if (hit_rise) begin
            pending_d = 1'b1;
        end else if (wr_status && bus_wdata_i[0]) begin
            pending_d = 1'b0;
        end

        // Freeze the upper half at the LO read so a LO/HI pair is coherent
        // even if a carry crosses bit 32 between the two accesses.
        if (rd_en && (bus_addr_i == A_MTIME_LO)) begin
            shadow_d = mtime_q[63:32];
        end
    end

    // Using pending_d keeps the interrupt one cycle behind the hit edge and
    // lets a W1C drop it together with PENDING. One-shot also holds the
    // level while mtime stays at or past mtimecmp.
    always_comb begin
        timeout_d = periodic_q ? pending_d : (hit || pending_d);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_q        <= 1'b0;
            periodic_q  <= 1'b0;
            prescale_q  <= '0;
            presc_cnt_q <= '0;
            period_q    <= 32'd0;
            pending_q   <= 1'b0;
            hit_q       <= 1'b0;
            timeout_q   <= 1'b0;
            shadow_q    <= 32'd0;
            ack_q       <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            en_q        <= en_d;
            periodic_q  <= periodic_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            period_q    <= period_d;
            pending_q   <= pending_d;
            hit_q       <= hit_d;
            timeout_q   <= timeout_d;
            shadow_q    <= shadow_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus_ack_o     = ack_q;
    assign bus_rdata_o   = rdata_q;
    assign timer_timeout = timeout_q;
    assign cmp_hit_o     = hit_rise;

endmodule

// File: tb/tb_machine_timer_irq_src.sv
// Bench for machine_timer_irq_src: directed steps from the test plan plus a
// randomized phase, every cycle checked against a behavioural model.
module tb_machine_timer_irq_src;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_req_i;
    logic        bus_we_i;
    logic [7:0]  bus_addr_i;
    logic [31:0] bus_wdata_i;
    logic        bus_ack_o;
    logic [31:0] bus_rdata_o;
    logic        count_en_i;
    logic        timer_timeout;
    logic        cmp_hit_o;

    machine_timer_irq_src #(.PRESCALE_W(16), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i),
        .bus_wdata_i(bus_wdata_i), .bus_ack_o(bus_ack_o), .bus_rdata_o(bus_rdata_o),
        .count_en_i(count_en_i), .timer_timeout(timer_timeout), .cmp_hit_o(cmp_hit_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state (plain integers)
    longint unsigned m_mtime, m_cmp;
    bit              m_en, m_per, m_pend, m_hitq, m_ack, m_to;
    int unsigned     m_presc, m_pcnt, m_period;
    logic [31:0]     m_rdata, m_shadow;

    localparam longint unsigned HI_MASK = 64'hFFFF_FFFF_0000_0000;
    localparam longint unsigned LO_MASK = 64'h0000_0000_FFFF_FFFF;

    task automatic model_reset();
        m_mtime = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en = 0; m_per = 0; m_pend = 0; m_hitq = 0; m_ack = 0; m_to = 0;
        m_presc = 0; m_pcnt = 0; m_period = 0; m_rdata = 0; m_shadow = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h00: return 32'(m_mtime);
            8'h04: return m_shadow;
            8'h08: return 32'(m_cmp);
            8'h0C: return 32'(m_cmp >> 32);
            8'h10: return {30'd0, m_per, m_en};
            8'h14: return m_presc;
            8'h18: return m_period;
            8'h1C: return {31'd0, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model over one clock edge using the inputs now on the pins.
    task automatic model_step();
        bit hit, rise, acc, wr, tick, old_per;
        longint unsigned old_mtime, old_cmp;
        if (reset) begin
            model_reset();
            return;
        end
        hit       = m_en && (m_mtime >= m_cmp);
        rise      = hit && !m_hitq;
        acc       = bus_req_i && !m_ack;
        wr        = acc && bus_we_i;
        tick      = m_en && count_en_i && (m_pcnt == m_presc);
        old_mtime = m_mtime;
        old_cmp   = m_cmp;
        old_per   = m_per;

        m_rdata = (acc && !bus_we_i) ? model_read(bus_addr_i) : 32'd0;
        if (acc && !bus_we_i && bus_addr_i == 8'h00) m_shadow = 32'(old_mtime >> 32);
        m_ack = acc;

        if (tick) begin
            m_mtime = m_mtime + 1;
            m_pcnt  = 0;
        end else if (m_en && count_en_i) begin
            m_pcnt = m_pcnt + 1;
        end
        if (rise && m_per) m_cmp = m_cmp + 64'(m_period);

        if (wr) begin
            case (bus_addr_i)
                8'h00: m_mtime = (old_mtime & HI_MASK) | 64'(bus_wdata_i);
                8'h04: m_mtime = (old_mtime & LO_MASK) | (64'(bus_wdata_i) << 32);
                8'h08: m_cmp   = (old_cmp & HI_MASK) | 64'(bus_wdata_i);
                8'h0C: m_cmp   = (old_cmp & LO_MASK) | (64'(bus_wdata_i) << 32);
                8'h10: begin m_en = bus_wdata_i[0]; m_per = bus_wdata_i[1]; end
                8'h14: begin m_presc = bus_wdata_i & 32'hFFFF; m_pcnt = 0; end
                8'h18: m_period = bus_wdata_i;
                8'h1C: if (bus_wdata_i[0]) m_pend = 0;
                default: ;
            endcase
        end
        if (rise) m_pend = 1;
        m_to   = old_per ? m_pend : (hit || m_pend);
        m_hitq = hit;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("ack", 32'(bus_ack_o), 32'(m_ack));
        chk("rdata", bus_rdata_o, m_rdata);
        chk("timeout", 32'(timer_timeout), 32'(m_to));
        chk("cmp_hit", 32'(cmp_hit_o), 32'(m_en && (m_mtime >= m_cmp) && !m_hitq));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        bus_req_i = 1'b0;
        repeat (n) step();
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = a; bus_wdata_i = d;
        step();
        bus_req_i = 1'b0; bus_we_i = 1'b0;
        step();
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = a;
        step();
        d = bus_rdata_o;
        bus_req_i = 1'b0;
        step();
    endtask

    task automatic wait_hit(input string tag);
        int n;
        n = 0;
        bus_req_i = 1'b0;
        while (!cmp_hit_o && n < 200) begin
            step();
            n++;
        end
        chk(tag, 32'(cmp_hit_o), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] rst_exp [9];
        int n;
        int k;
        rst_exp = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

        reset = 1'b1; bus_req_i = 1'b0; bus_we_i = 1'b0; bus_addr_i = 8'h0;
        bus_wdata_i = 32'h0; count_en_i = 1'b0;
        model_reset();
        step(); step();
        reset = 1'b0;
        chk("rst_timeout", 32'(timer_timeout), 32'd0);

        // Reset values of every register, plus an unmapped offset.
        for (int i = 0; i < 9; i++) begin
            bus_rd(8'(i * 4), d);
            chk("rst_read", d, rst_exp[i]);
        end

        // One-shot with prescale 3.
        bus_wr(8'h14, 32'd3);
        bus_wr(8'h0C, 32'd0);
        bus_wr(8'h08, 32'd10);
        count_en_i = 1'b1;
        bus_wr(8'h10, 32'd1);
        wait_hit("oneshot_hit");
        step();
        chk("oneshot_to_rise", 32'(timer_timeout), 32'd1);
        bus_rd(8'h00, d);
        chk("oneshot_mtime", d, 32'd10);
        bus_wr(8'h1C, 32'd1);
        idle(3);
        chk("oneshot_hold", 32'(timer_timeout), 32'd1);
        bus_wr(8'h08, 32'd100);
        chk("oneshot_drop", 32'(timer_timeout), 32'd0);
        bus_rd(8'h1C, d);
        chk("oneshot_pend", d, 32'd0);

        // Periodic, period 5, prescale 0.
        bus_wr(8'h10, 32'd0);
        bus_wr(8'h14, 32'd0);
        bus_wr(8'h00, 32'd0);
        bus_wr(8'h04, 32'd0);
        bus_wr(8'h18, 32'd5);
        bus_wr(8'h0C, 32'd0);
        bus_wr(8'h08, 32'd5);
        bus_wr(8'h1C, 32'd1);
        bus_wr(8'h10, 32'd3);
        wait_hit("per_hit1");
        step();
        bus_wr(8'h1C, 32'd1);
        chk("per_cleared", 32'(timer_timeout), 32'd0);
        wait_hit("per_hit2");
        step();
        chk("per_reset", 32'(timer_timeout), 32'd1);
        bus_wr(8'h1C, 32'd1);
        n = 0;
        while (!(m_en && (m_mtime >= m_cmp) && !m_hitq) && n < 50) begin
            step();
            n++;
        end
        chk("per_hit3", 32'(cmp_hit_o), 32'd1);
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = 8'h1C; bus_wdata_i = 32'd1;
        step();
        bus_req_i = 1'b0;
        step();
        bus_rd(8'h1C, d);
        chk("per_w1c_coinc", d, 32'd1);
        bus_wr(8'h10, 32'd0);
        bus_rd(8'h08, d);
        chk("per_cmp", d, 32'd20);

        // Wrap through 2^64.
        count_en_i = 1'b0;
        bus_wr(8'h04, 32'hFFFF_FFFF);
        bus_wr(8'h00, 32'hFFFF_FFFE);
        bus_wr(8'h10, 32'd1);
        count_en_i = 1'b1;
        idle(3);
        count_en_i = 1'b0;
        bus_rd(8'h00, d);
        chk("wrap_lo", d, 32'd1);
        bus_rd(8'h04, d);
        chk("wrap_hi", d, 32'd0);

        // Carry between LO and HI reads.
        bus_wr(8'h04, 32'd0);
        bus_wr(8'h00, 32'hFFFF_FFFE);
        count_en_i = 1'b1;
        bus_rd(8'h00, d);
        chk("tear_lo", d, 32'hFFFF_FFFE);
        bus_rd(8'h04, d);
        chk("tear_hi_shadow", d, 32'd0);
        count_en_i = 1'b0;
        bus_rd(8'h00, d);
        bus_rd(8'h04, d);
        chk("tear_hi_after", d, 32'd1);

        // Count enable low holds time; held request is not re-accepted.
        bus_wr(8'h14, 32'd3);
        idle(6);
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 8'h10;
        repeat (3) step();
        bus_req_i = 1'b0;
        step();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            reset       = ($urandom_range(0, 149) == 0);
            bus_req_i   = 1'($urandom_range(0, 1));
            bus_we_i    = 1'($urandom_range(0, 1));
            k           = $urandom_range(0, 9);
            bus_addr_i  = (k < 8) ? 8'(k * 4) : ((k == 8) ? 8'h20 : 8'h0A);
            count_en_i  = ($urandom_range(0, 4) != 0);
            case (bus_addr_i)
                8'h00:   bus_wdata_i = $urandom_range(0, 40);
                8'h04:   bus_wdata_i = ($urandom_range(0, 9) == 0) ? 32'd1 : 32'd0;
                8'h08:   bus_wdata_i = 32'(m_mtime) + $urandom_range(0, 30);
                8'h0C:   bus_wdata_i = 32'(m_mtime >> 32);
                8'h10:   bus_wdata_i = $urandom | ($urandom_range(0, 3) != 0 ? 32'd1 : 32'd0);
                8'h14:   bus_wdata_i = $urandom & 32'hFFFF_0003;
                8'h18:   bus_wdata_i = $urandom_range(0, 8);
                default: bus_wdata_i = $urandom;
            endcase
            step();
        end
        reset = 1'b0;
        idle(2);

        // Reset coincident with an outstanding read drops the access.
        bus_wr(8'h10, 32'd1);
        bus_wr(8'h08, 32'd0);
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 8'h08; reset = 1'b1;
        step();
        chk("rst_noack", 32'(bus_ack_o), 32'd0);
        chk("rst_rdata", bus_rdata_o, 32'd0);
        chk("rst_to", 32'(timer_timeout), 32'd0);
        chk("rst_hit", 32'(cmp_hit_o), 32'd0);
        reset = 1'b0; bus_req_i = 1'b0;
        idle(2);
        bus_rd(8'h0C, d);
        chk("rst_cmp_hi", d, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
